pc_fetch_unit: RTL

- Program-counter register and instruction-fetch sequencer: the producer side of the PC path that the PC incrementer consumes.
- Holds the current PC and issues fetch requests to instruction memory with a req/ack handshake.
- Presents fetched instructions to the IF/ID stage through a valid/ready handshake.
- Advances the PC with wrap-around, honours pipeline stalls, and redirects on taken branches.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pc_reg.sv | 79 +++++++
 rtl/pc_fetch_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the PC path of the pipeline front end.
//   - fetch_state_t : fetch sequencer states (IDLE, REQ, HOLD)
//   - *_DEFAULT     : default PC width, instruction width and last legal PC
//   - pc_next()     : sequential PC rule with wrap-around, shared with the
//                     PC incrementer so both sides agree on the successor PC
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int PC_W_DEFAULT    = 4;
  localparam int INSTR_W_DEFAULT = 32;
  localparam int MAX_PC_DEFAULT  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Successor of pc. Anything at or above max_pc (only reachable through a
  // branch target) wraps to 0. The caller truncates the result to its PC width.
  function automatic int unsigned pc_next(input int unsigned pc,
                                          input int unsigned max_pc);
    return (pc >= max_pc) ? 32'd0 : pc + 32'd1;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program-counter register with load / increment / hold control.
// Load has priority over increment; with neither asserted the PC holds.
//
// Optional feature (macro PC_WRAP_FLAG_EN): wrap_o pulses for one clock in the
// cycle after an increment takes the PC from its last legal value back to 0.
//
// Ports:
//   clk, reset     system clock (rising edge), async active-high reset
//   load_i         load load_pc_i into the PC (redirect)
//   load_pc_i      PC_W  value to load
//   inc_i          advance the PC to its sequential successor
//   pc_o           PC_W  current PC
//   next_pc_o      PC_W  sequential successor of pc_o (combinational)
//   wrap_o         wrap pulse (PC_WRAP_FLAG_EN only)
// -----------------------------------------------------------------------------
module pc_reg
  import pipe_pkg::*;
#(
  parameter int PC_W     = PC_W_DEFAULT,
  parameter int MAX_PC   = MAX_PC_DEFAULT,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [PC_W-1:0] load_pc_i,
  input  logic            inc_i,
`ifdef PC_WRAP_FLAG_EN
  output logic            wrap_o,
`endif
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] next_pc_o
);

  logic [PC_W-1:0] pc_q, pc_d;

  assign next_pc_o = PC_W'(pc_next(32'(pc_q), 32'(MAX_PC)));

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = next_pc_o;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers, matching real hardware.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= PC_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

`ifdef PC_WRAP_FLAG_EN
  logic wrap_q, wrap_d;

  // Only a sequential step lands on 0 here; a load (branch) to 0 never pulses.
  assign wrap_d = inc_i && !load_i && (next_pc_o == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;
`endif

endmodule

// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program-counter register and instruction-fetch sequencer. Issues fetches to
// instruction memory over a req/ack handshake, presents each fetched word to
// IF/ID over a valid/ready handshake, advances the PC with wrap-around,
// honours stalls and redirects on taken branches. All outputs are registered.
//
// Optional feature (macro PC_WRAP_FLAG_EN): adds wrap_o, a one-clock pulse in
// the cycle after the PC steps from MAX_PC to 0 by increment.
//
// Ports:
//   clk, reset       system clock (rising edge), async active-high reset
//   stall_i          hold PC and issue no new request
//   branch_taken_i   single-cycle redirect strobe
//   branch_target_i  PC_W     redirect target
//   imem_req_o       fetch request, held until imem_ack_i
//   imem_addr_o      PC_W     fetch address, stable while imem_req_o=1
//   imem_ack_i       memory returns imem_data_i this cycle
//   imem_data_i      INSTR_W  instruction word
//   if_valid_o       if_pc_o / if_instr_o are valid
//   if_ready_i       IF/ID accepts this cycle
//   if_pc_o          PC_W     PC of the presented instruction
//   if_instr_o       INSTR_W  presented instruction
//   wrap_o           wrap pulse (PC_WRAP_FLAG_EN only)
// -----------------------------------------------------------------------------
module pc_fetch_unit
  import pipe_pkg::*;
#(
  parameter int PC_W     = PC_W_DEFAULT,
  parameter int INSTR_W  = INSTR_W_DEFAULT,
  parameter int RESET_PC = 0,
  parameter int MAX_PC   = MAX_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               branch_taken_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
`ifdef PC_WRAP_FLAG_EN
  output logic               wrap_o,
`endif
  output logic               if_valid_o,
  input  logic               if_ready_i,
  output logic [PC_W-1:0]    if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o
);

  fetch_state_t       state_q, state_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               valid_q, valid_d;
  logic [PC_W-1:0]    if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  // Set when a branch lands while a request is outstanding; the returning
  // data then belongs to the wrong path and is thrown away.
  logic               squash_q, squash_d;

  logic               pc_load;
  logic               pc_inc;
  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    pc_succ;

  // Fetch launch request from the state logic: start a new REQ next cycle.
  logic               launch;
  logic [PC_W-1:0]    launch_addr;

  pc_reg #(
    .PC_W     (PC_W),
    .MAX_PC   (MAX_PC),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (pc_load),
    .load_pc_i (branch_target_i),
    .inc_i     (pc_inc),
`ifdef PC_WRAP_FLAG_EN
    .wrap_o    (wrap_o),
`endif
    .pc_o      (pc_q),
    .next_pc_o (pc_succ)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    squash_d    = squash_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    launch      = 1'b0;
    launch_addr = pc_q;

    case (state_q)
      IDLE: begin
        if (branch_taken_i) begin
          pc_load     = 1'b1;
          launch      = !stall_i;
          launch_addr = branch_target_i;
        end else begin
          launch = !stall_i;
        end
      end

      REQ: begin
        if (imem_ack_i) begin
          req_d    = 1'b0;
          squash_d = 1'b0;
          if (branch_taken_i) begin
            // Data returning in the redirect cycle is on the old path.
            pc_load     = 1'b1;
            state_d     = IDLE;
            launch      = !stall_i;
            launch_addr = branch_target_i;
          end else if (squash_q) begin
            state_d = IDLE;
          end else begin
            valid_d    = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_data_i;
            state_d    = HOLD;
          end
        end else if (branch_taken_i) begin
          // The memory still owes us this beat; let it finish, then drop it.
          pc_load  = 1'b1;
          squash_d = 1'b1;
        end
      end

      HOLD: begin
        if (branch_taken_i) begin
          // Redirect beats a same-cycle accept: the held word is dropped.
          valid_d     = 1'b0;
          pc_load     = 1'b1;
          state_d     = IDLE;
          launch      = !stall_i;
          launch_addr = branch_target_i;
        end else if (if_ready_i) begin
          valid_d     = 1'b0;
          pc_inc      = 1'b1;
          state_d     = IDLE;
          launch      = !stall_i;
          launch_addr = pc_succ;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (launch) begin
      state_d = REQ;
      req_d   = 1'b1;
      addr_d  = launch_addr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= PC_W'(RESET_PC);
      valid_q    <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      squash_q   <= squash_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;

endmodule
